// File: rtl/sensores_multi.sv
// Multi-lane vehicle passage detector: per-lane sync/debounce, direction FSM
// with dwell timeout, and a saturating occupancy counter with sticky flags.
module sensores_multi #(
  parameter int LANES   = 2,
  parameter int CAP     = 16,
  parameter int DEB     = 3,
  parameter int TIMEOUT = 1000,
  parameter int CW      = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  output logic [LANES-1:0] x0,
  output logic [LANES-1:0] y0,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int LW = $clog2(LANES + 1);
  localparam int SW = CW + LW + 1;

  typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3} state_t;

  logic [LANES-1:0] w_ent;
  logic [LANES-1:0] w_ext;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    // Sensor index 1 carries a, index 0 carries b.
    logic [1:0]    r_m1;
    logic [1:0]    r_m2;
    logic [1:0]    r_flt;
    logic [DW-1:0] r_dc [2];
    state_t        r_st;
    state_t        w_nx;
    logic [TW-1:0] r_tmo;
    logic          w_ent_l;
    logic          w_ext_l;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_m1     <= '0;
        r_m2     <= '0;
        r_flt    <= '0;
        r_dc[0]  <= '0;
        r_dc[1]  <= '0;
      end else begin
        r_m1 <= {a[gi], b[gi]};
        r_m2 <= r_m1;
        for (int unsigned k = 0; k < 2; k++) begin
          if (r_m2[k] == r_flt[k]) begin
            r_dc[k] <= '0;
          end else if (r_dc[k] == DW'(DEB - 1)) begin
            r_flt[k] <= r_m2[k];
            r_dc[k]  <= '0;
          end else begin
            r_dc[k] <= r_dc[k] + 1'b1;
          end
        end
      end
    end

    always_comb begin
      w_nx    = r_st;
      w_ent_l = 1'b0;
      w_ext_l = 1'b0;
      case (r_st)
        IDLE: begin
          if (r_flt == 2'b10)      w_nx = E1;
          else if (r_flt == 2'b01) w_nx = X1;
        end
        E1: begin
          if (r_flt == 2'b11)                          w_nx = E2;
          else if (r_flt == 2'b00 || r_flt == 2'b01)   w_nx = IDLE;
        end
        E2: begin
          if (r_flt == 2'b01)      w_nx = E3;
          else if (r_flt == 2'b10) w_nx = E1;
          else if (r_flt == 2'b00) w_nx = IDLE;
        end
        E3: begin
          if (r_flt == 2'b00) begin
            w_nx    = IDLE;
            w_ent_l = 1'b1;
          end else if (r_flt == 2'b11) w_nx = E2;
          else if (r_flt == 2'b10)     w_nx = IDLE;
        end
        X1: begin
          if (r_flt == 2'b11)                          w_nx = X2;
          else if (r_flt == 2'b00 || r_flt == 2'b10)   w_nx = IDLE;
        end
        X2: begin
          if (r_flt == 2'b10)      w_nx = X3;
          else if (r_flt == 2'b01) w_nx = X1;
          else if (r_flt == 2'b00) w_nx = IDLE;
        end
        X3: begin
          if (r_flt == 2'b00) begin
            w_nx    = IDLE;
            w_ext_l = 1'b1;
          end else if (r_flt == 2'b11) w_nx = X2;
          else if (r_flt == 2'b01)     w_nx = IDLE;
        end
        default: w_nx = IDLE;
      endcase
      // A real transition on the expiry cycle takes precedence over the abort.
      if (w_nx == r_st && r_st != IDLE && r_tmo == TW'(TIMEOUT - 1)) begin
        w_nx = IDLE;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_st  <= IDLE;
        r_tmo <= '0;
      end else begin
        r_st <= w_nx;
        if (w_nx != r_st || r_st == IDLE) r_tmo <= '0;
        else                              r_tmo <= r_tmo + 1'b1;
      end
    end

    assign w_ent[gi] = w_ent_l;
    assign w_ext[gi] = w_ext_l;
  end

  logic [LANES-1:0]      r_x0;
  logic [LANES-1:0]      r_y0;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_unf;
  logic signed [SW-1:0]  w_sum;
  logic [CW-1:0]         w_cnt_nx;
  logic                  w_ovf_set;
  logic                  w_unf_set;

  // Entries and exits net out before clamping to [0, CAP].
  always_comb begin
    w_sum = $signed({{(SW - CW){1'b0}}, r_count});
    for (int unsigned k = 0; k < LANES; k++) begin
      if (w_ent[k]) w_sum = w_sum + SW'(1);
      if (w_ext[k]) w_sum = w_sum - SW'(1);
    end
    w_cnt_nx  = w_sum[CW-1:0];
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (w_sum > $signed(SW'(CAP))) begin
      w_cnt_nx  = CW'(CAP);
      w_ovf_set = 1'b1;
    end else if (w_sum < $signed(SW'(0))) begin
      w_cnt_nx  = '0;
      w_unf_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_x0    <= w_ent;
      r_y0    <= w_ext;
      r_count <= w_cnt_nx;
      r_ovf   <= r_ovf | w_ovf_set;
      r_unf   <= r_unf | w_unf_set;
    end
  end

  assign x0    = r_x0;
  assign y0    = r_y0;
  assign count = r_count;
  assign full  = (r_count == CW'(CAP));
  assign empty = (r_count == '0);
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_sensores_multi.sv
// Bench for sensores_multi: directed scenarios with literal expectations plus
// randomized lane activity, all checked every cycle against a behavioural model.
module tb_sensores_multi;

  localparam int LANES = 2;
  localparam int CAP   = 3;
  localparam int DEB   = 3;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] a = '0;
  logic [1:0] b = '0;
  logic [1:0] x0, y0;
  logic [1:0] count;
  logic       full, empty, ovf, unf;

  int nchecks = 0;
  int nfail   = 0;

  sensores_multi #(.LANES(LANES), .CAP(CAP), .DEB(DEB), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .x0(x0), .y0(y0),
    .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // Level sequence of a passage: entry 10,11,01,00; exit 01,11,10,00 ({a,b}).
  function automatic int lvl(input int sg, input int i);
    if (sg > 0) begin
      case (i) 0: return 2; 1: return 3; 2: return 1; default: return 0; endcase
    end else begin
      case (i) 0: return 1; 1: return 3; 2: return 2; default: return 0; endcase
    end
  endfunction

  // ---------------- behavioural model ----------------
  // pos: 0 idle, +k = k steps into an entry, -k = k steps into an exit.
  int       pos   [LANES];
  int       dwell [LANES];
  bit [1:0] s1    [LANES];
  bit [1:0] s2    [LANES];
  bit [1:0] flt   [LANES];
  bit [7:0] hist  [LANES][2];
  bit [1:0] ex0, ey0;
  int       ecnt;
  bit       eovf, eunf;
  bit       started = 0;

  always @(posedge clk) begin
    int e, x, np, k, sg, v, n;
    bit [7:0] w;
    bit [7:0] msk;
    started <= 1;
    msk = 8'((1 << DEB) - 1);
    if (!reset) begin
      for (int l = 0; l < LANES; l++) begin
        pos[l] = 0; dwell[l] = 0; s1[l] = 0; s2[l] = 0; flt[l] = 0;
        hist[l][0] = 0; hist[l][1] = 0;
      end
      ex0 = 0; ey0 = 0; ecnt = 0; eovf = 0; eunf = 0;
    end else begin
      e = 0; x = 0; ex0 = 0; ey0 = 0;
      for (int l = 0; l < LANES; l++) begin
        v  = int'(flt[l]);
        np = pos[l];
        if (pos[l] == 0) begin
          if (v == 2) np = 1;
          else if (v == 1) np = -1;
        end else begin
          sg = (pos[l] > 0) ? 1 : -1;
          k  = (pos[l] > 0) ? pos[l] : -pos[l];
          if (v == lvl(sg, k - 1)) np = pos[l];
          else if (v == lvl(sg, k)) begin
            if (k == 3) begin
              np = 0;
              if (sg > 0) begin e++; ex0[l] = 1; end
              else begin x++; ey0[l] = 1; end
            end else np = sg * (k + 1);
          end else if (k >= 2 && v == lvl(sg, k - 2)) np = sg * (k - 1);
          else np = 0;
          if (np == pos[l] && dwell[l] == TMO - 1) np = 0;
        end
        if (np != pos[l] || pos[l] == 0) dwell[l] = 0;
        else dwell[l] = dwell[l] + 1;
        pos[l] = np;
        // Filter flips once DEB consecutive synchronised samples disagree with it.
        for (int s = 0; s < 2; s++) begin
          hist[l][s] = {hist[l][s][6:0], s2[l][s]};
          w = hist[l][s] & msk;
          if ((flt[l][s] == 1'b0 && w == msk) || (flt[l][s] == 1'b1 && w == 8'd0))
            flt[l][s] = ~flt[l][s];
        end
        s2[l] = s1[l];
        s1[l] = {a[l], b[l]};
      end
      n = ecnt + e - x;
      if (n > CAP) begin ecnt = CAP; eovf = 1; end
      else if (n < 0) begin ecnt = 0; eunf = 1; end
      else ecnt = n;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("x0", int'(x0), int'(ex0));
      chk("y0", int'(y0), int'(ey0));
      chk("count", int'(count), ecnt);
      chk("full", int'(full), int'(ecnt == CAP));
      chk("empty", int'(empty), int'(ecnt == 0));
      chk("ovf", int'(ovf), int'(eovf));
      chk("unf", int'(unf), int'(eunf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic setl(input int l, input int v);
    a[l] = v[1];
    b[l] = v[0];
  endtask

  task automatic hold(input int l, input int v, input int n);
    @(negedge clk);
    setl(l, v);
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pass(input int l, input int sg);
    for (int i = 0; i < 4; i++) hold(l, lvl(sg, i), 8);
  endtask

  task automatic pass2(input int sg0, input int sg1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      setl(0, lvl(sg0, i));
      setl(1, lvl(sg1, i));
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hc [LANES];
    int pi [LANES];
    int dir [LANES];
    int r;
    bit do_rst;

    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    reset = 1'b1;

    // Entry on lane 0 with exact pulse timing.
    hold(0, 2, 8); hold(0, 3, 8); hold(0, 1, 8);
    @(negedge clk);
    setl(0, 0);
    repeat (5) @(negedge clk);
    chk("entry_pre_x0", int'(x0), 0);
    chk("entry_pre_empty", int'(empty), 1);
    @(negedge clk);
    chk("entry_x0", int'(x0), 1);
    chk("entry_count", int'(count), 1);
    chk("entry_empty", int'(empty), 0);
    @(negedge clk);
    chk("entry_x0_width", int'(x0), 0);
    repeat (4) @(negedge clk);

    // Exit on lane 1, then a backed-out entry on lane 0.
    pass(1, -1);
    chk("exit_count", int'(count), 0);
    hold(0, 2, 8); hold(0, 3, 8); hold(0, 2, 8); hold(0, 0, 8);
    chk("abort_count", int'(count), 0);

    // Glitch, then timeout, then a counted entry.
    hold(0, 2, 2); hold(0, 0, 10);
    hold(0, 2, 30); hold(0, 0, 10);
    chk("timeout_count", int'(count), 0);
    pass(0, 1);
    chk("after_timeout_count", int'(count), 1);

    // Saturation and underflow.
    pass(0, 1); pass(0, 1);
    chk("sat_full", int'(full), 1);
    chk("sat_ovf_pre", int'(ovf), 0);
    pass(0, 1);
    chk("sat_count", int'(count), 3);
    chk("sat_ovf", int'(ovf), 1);
    pass(1, -1); pass(1, -1); pass(1, -1);
    chk("drain_unf_pre", int'(unf), 0);
    pass(1, -1);
    chk("unf_count", int'(count), 0);
    chk("unf_flag", int'(unf), 1);

    // Simultaneous lanes.
    rst_pulse();
    pass(0, 1); pass(0, 1); pass(0, 1);
    pass2(1, -1);
    chk("simul_count", int'(count), 3);
    chk("simul_ovf", int'(ovf), 0);
    pass(0, -1); pass(0, -1);
    pass2(-1, -1);
    chk("dual_exit_count", int'(count), 0);
    chk("dual_exit_unf", int'(unf), 1);

    // Reset mid-sequence.
    rst_pulse();
    pass(0, 1); pass(0, 1);
    hold(0, 2, 8); hold(0, 3, 8);
    chk("mid_count_pre", int'(count), 2);
    rst_pulse();
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_unf", int'(unf), 0);
    chk("mid_rst_x0", int'(x0), 0);
    hold(0, 1, 8); hold(0, 0, 8);
    chk("mid_after_count", int'(count), 0);

    // Randomized activity on both lanes.
    for (int l = 0; l < LANES; l++) begin hc[l] = 0; pi[l] = 0; dir[l] = 1; end
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      do_rst = ($urandom_range(0, 1499) == 0);
      reset = do_rst ? 1'b0 : 1'b1;
      for (int l = 0; l < LANES; l++) begin
        if (hc[l] == 0) begin
          r = int'($urandom_range(0, 99));
          if (r < 75) begin
            setl(l, lvl(dir[l], pi[l]));
            pi[l] = pi[l] + 1;
            if (pi[l] == 4) begin
              pi[l] = 0;
              dir[l] = ($urandom_range(0, 1) == 0) ? 1 : -1;
            end
          end else begin
            setl(l, int'($urandom_range(0, 3)));
          end
          hc[l] = int'($urandom_range(1, 10));
          if (r >= 97) hc[l] = 25;
        end else begin
          hc[l] = hc[l] - 1;
        end
      end
    end
    reset = 1'b1;
    a = '0; b = '0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
